// File: rtl/regaccess_master.sv
// regaccess_master: SPI mode-0 initiator issuing one 16-bit frame
// {rw, regnum[6:0], data[7:0]} per request to the register-access slave.
// Read data is taken from the 8 miso bits sampled during the data byte.
module regaccess_master #(
   parameter int unsigned CLK_DIV  = 4,
   parameter int unsigned SS_SETUP = 2,
   parameter int unsigned SS_HOLD  = 2,
   parameter int unsigned SS_IDLE  = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       rw,
   input  logic [6:0] regnum,
   input  logic [7:0] wdata,
   output logic       busy,
   output logic       done,
   output logic [7:0] rdata,
   output logic       ss,
   output logic       sclk,
   output logic       mosi,
   input  logic       miso
);

   localparam int unsigned M1   = (CLK_DIV > SS_SETUP) ? CLK_DIV : SS_SETUP;
   localparam int unsigned M2   = (SS_HOLD > SS_IDLE) ? SS_HOLD : SS_IDLE;
   localparam int unsigned MAXC = (M1 > M2) ? M1 : M2;
   localparam int unsigned CW   = $clog2(MAXC + 1);

   localparam logic [CW-1:0] SETUP_LAST = CW'(SS_SETUP - 1);
   localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] HOLD_LAST  = CW'(SS_HOLD - 1);
   localparam logic [CW-1:0] IDLE_LAST  = CW'(SS_IDLE - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_SHIFT,
      S_HOLD,
      S_DONE,
      S_GAP
   } state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [3:0]      bit_cnt;
   logic [15:0]     tx;
   logic [7:0]      rx;
   logic            rw_q;

   // Frame sequencer: all SPI pins, busy, done and rdata are registered here.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         cnt     <= '0;
         bit_cnt <= '0;
         tx      <= '0;
         rx      <= '0;
         rw_q    <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         rdata   <= '0;
         ss      <= 1'b1;
         sclk    <= 1'b0;
         mosi    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               ss   <= 1'b1;
               sclk <= 1'b0;
               if (start) begin
                  tx      <= {rw, regnum, (rw ? wdata : 8'h00)};
                  rw_q    <= rw;
                  mosi    <= rw;
                  busy    <= 1'b1;
                  ss      <= 1'b0;
                  cnt     <= '0;
                  bit_cnt <= '0;
                  state   <= S_SETUP;
               end
            end
            S_SETUP: begin
               if (cnt == SETUP_LAST) begin
                  cnt   <= '0;
                  state <= S_SHIFT;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_SHIFT: begin
               if (cnt == DIV_LAST) begin
                  cnt <= '0;
                  if (!sclk) begin
                     // rising edge: sample miso; the last 8 samples are the data byte
                     sclk <= 1'b1;
                     rx   <= {rx[6:0], miso};
                  end else begin
                     sclk <= 1'b0;
                     if (bit_cnt == 4'd15) begin
                        state <= S_HOLD;
                     end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                        tx      <= {tx[14:0], 1'b0};
                        mosi    <= tx[14];
                     end
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_HOLD: begin
               if (cnt == HOLD_LAST) begin
                  ss    <= 1'b1;
                  done  <= 1'b1;
                  if (!rw_q) begin
                     rdata <= rx;
                  end
                  state <= S_DONE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_DONE: begin
               // the DONE cycle is the first of the SS_IDLE gap cycles
               if (SS_IDLE == 1) begin
                  busy  <= 1'b0;
                  mosi  <= 1'b0;
                  state <= S_IDLE;
               end else begin
                  cnt   <= CW'(1);
                  state <= S_GAP;
               end
            end
            S_GAP: begin
               if (cnt == IDLE_LAST) begin
                  busy  <= 1'b0;
                  mosi  <= 1'b0;
                  state <= S_IDLE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               ss    <= 1'b1;
               sclk  <= 1'b0;
               mosi  <= 1'b0;
            end
         endcase
      end
   end

endmodule
